// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation control block: register map,
// STATUS layout, FSM encoding and the watchdog exit code.
package sim_ctrl_pkg;

  localparam logic [7:0] OFF_CONSOLE  = 8'h00;
  localparam logic [7:0] OFF_EXIT     = 8'h04;
  localparam logic [7:0] OFF_CYCLE_LO = 8'h08;
  localparam logic [7:0] OFF_CYCLE_HI = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_STATE_LSB = 1;

  localparam logic [31:0] WATCHDOG_CODE = 32'hDEAD_0001;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Decoded view of the current bus request.
  typedef struct packed {
    logic       sel;
    logic       wr;
    logic [7:0] off;
  } req_t;

  function automatic logic [31:0] status_word(input state_e st, input logic full);
    logic [31:0] w;
    w = '0;
    w[STATUS_FULL_BIT] = full;
    w[STATUS_STATE_LSB +: 2] = st;
    return w;
  endfunction

endpackage

// File: rtl/sim_ctrl_fifo.sv
// Console byte FIFO with push/pop handshakes and an occupancy count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sim_ctrl_fifo
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // NOTE: all state updates in clocked blocks use <= so every register sees
  // the pre-edge value of every other register, independent of block order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it was written, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/sim_ctrl.sv
// Memory-mapped simulation controller: console output FIFO, exit request,
// free-running cycle counter and an optional watchdog that ends the run.
module sim_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned WATCHDOG_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic [31:0] exit_code,
  output logic        trap
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam bit          WD_EN   = (WATCHDOG_CYCLES != 0);
  localparam logic [63:0] WD_LAST = 64'(WATCHDOG_CYCLES) - 64'd1;

  state_e      state;
  state_e      state_next;
  req_t        req;
  logic [63:0] cycle_cnt;
  logic [31:0] cycle_hi_snap;
  logic [31:0] rd_mux;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [CW-1:0] fifo_count;

  logic running;
  logic push_req;
  logic stall;
  logic ack;
  logic exit_wr;
  logic wd_fire;

  assign req.sel = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
  assign req.wr  = |mem_wstrb;
  assign req.off = mem_addr[7:0];

  assign running  = (state == ST_RUN);
  assign tx_valid = !fifo_empty;
  assign fifo_pop = tx_valid && tx_ready;

  // Only RUN-state console writes with byte 0 enabled reach the FIFO; everything
  // else acks without waiting.
  assign push_req  = req.sel && running && (req.off == OFF_CONSOLE) && mem_wstrb[0];
  assign stall     = push_req && fifo_full && !fifo_pop;
  assign ack       = req.sel && !mem_ready && !stall;
  assign fifo_push = ack && push_req;
  assign exit_wr   = ack && running && req.wr && (req.off == OFF_EXIT);
  assign wd_fire   = WD_EN && running && (cycle_cnt == WD_LAST);

  sim_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (mem_wdata[7:0]),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (tx_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_RUN;
    else         state <= state_next;
  end

  // NOTE: every signal assigned in a combinational block gets a default at the
  // top, so no path through the case statements can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (exit_wr || wd_fire) state_next = ST_DRAIN;
      ST_DRAIN: if (fifo_empty)         state_next = ST_DONE;
      ST_DONE:  state_next = ST_DONE;
      default:  state_next = ST_RUN;
    endcase
  end

  always_comb begin
    done = (state != ST_RUN);
    trap = (state == ST_DONE);
  end

  always_comb begin
    rd_mux = '0;
    if (!req.wr) begin
      case (req.off)
        OFF_CONSOLE:  rd_mux = 32'(fifo_count);
        OFF_EXIT:     rd_mux = exit_code;
        OFF_CYCLE_LO: rd_mux = cycle_cnt[31:0];
        OFF_CYCLE_HI: rd_mux = cycle_hi_snap;
        OFF_STATUS:   rd_mux = status_word(state, fifo_full);
        default:      rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_ready     <= 1'b0;
      mem_rdata     <= '0;
      cycle_cnt     <= '0;
      cycle_hi_snap <= '0;
      exit_code     <= '0;
    end else begin
      mem_ready <= ack;
      mem_rdata <= ack ? rd_mux : '0;
      if (state != ST_DONE) cycle_cnt <= cycle_cnt + 64'd1;
      // Reading LO freezes the upper half so a following HI read is coherent.
      if (ack && !req.wr && (req.off == OFF_CYCLE_LO)) cycle_hi_snap <= cycle_cnt[63:32];
      if (exit_wr)      exit_code <= mem_wdata;
      else if (wd_fire) exit_code <= WATCHDOG_CODE;
    end
  end

endmodule

// File: tb/tb_sim_ctrl.sv
// Self-checking bench for sim_ctrl: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_sim_ctrl;
  import sim_ctrl_pkg::*;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;
  localparam int          WD    = 1000;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        done;
  logic [31:0] exit_code;
  logic        trap;

  sim_ctrl #(
    .BASE_ADDR       (BASE),
    .FIFO_DEPTH      (DEPTH),
    .WATCHDOG_CYCLES (WD)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .done      (done),
    .exit_code (exit_code),
    .trap      (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned m_q[$];
  state_e       m_state;
  logic [63:0]  m_cnt;
  logic [31:0]  m_snap;
  logic [31:0]  m_exit;
  logic [31:0]  m_rdata;
  logic         m_ready;
  bit           model_live = 0;
  int           preload_seq = 0;
  int           preload_seen = 0;
  logic [63:0]  preload_val = '0;

  always @(posedge clk) begin : model
    logic       sel, wr, want_push, pop, ack;
    logic [7:0] off;
    logic [31:0] rd;
    if (preload_seq != preload_seen) begin
      m_cnt = preload_val;
      preload_seen = preload_seq;
    end
    if (!resetn) begin
      m_q.delete();
      m_state = ST_RUN;
      m_cnt = '0;
      m_snap = '0;
      m_exit = '0;
      m_ready = 1'b0;
      m_rdata = '0;
      model_live = 1;
    end else begin
      sel = mem_valid && (mem_addr[31:8] == BASE[31:8]);
      off = mem_addr[7:0];
      wr = (mem_wstrb != 4'h0);
      pop = (m_q.size() != 0) && tx_ready;
      want_push = sel && (m_state == ST_RUN) && (off == OFF_CONSOLE) && mem_wstrb[0];
      ack = sel && !m_ready && !(want_push && (m_q.size() == DEPTH) && !pop);
      rd = '0;
      if (ack && !wr) begin
        if (off == OFF_CONSOLE)  rd = 32'(m_q.size());
        if (off == OFF_EXIT)     rd = m_exit;
        if (off == OFF_CYCLE_LO) begin rd = m_cnt[31:0]; m_snap = m_cnt[63:32]; end
        if (off == OFF_CYCLE_HI) rd = m_snap;
        if (off == OFF_STATUS)   rd = 32'({m_state, (m_q.size() == DEPTH)});
      end
      if (m_state == ST_RUN) begin
        if (ack && wr && off == OFF_EXIT) begin
          m_exit = mem_wdata;
          m_state = ST_DRAIN;
          m_cnt = m_cnt + 64'd1;
        end else if (m_cnt == 64'(WD - 1)) begin
          m_exit = 32'hDEAD_0001;
          m_state = ST_DRAIN;
          m_cnt = m_cnt + 64'd1;
        end else begin
          m_cnt = m_cnt + 64'd1;
        end
      end else if (m_state == ST_DRAIN) begin
        m_cnt = m_cnt + 64'd1;
        if (m_q.size() == 0) m_state = ST_DONE;
      end
      if (pop) void'(m_q.pop_front());
      if (ack && want_push) m_q.push_back(mem_wdata[7:0]);
      m_ready = ack;
      m_rdata = rd;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("cmp_mem_ready", 64'(mem_ready), 64'(m_ready));
      check("cmp_mem_rdata", 64'(mem_rdata), 64'(m_rdata));
      check("cmp_tx_valid", 64'(tx_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) check("cmp_tx_data", 64'(tx_data), 64'(m_q[0]));
      check("cmp_done", 64'(done), 64'(m_state != ST_RUN));
      check("cmp_trap", 64'(trap), 64'(m_state == ST_DONE));
      check("cmp_exit_code", 64'(exit_code), 64'(m_exit));
    end
  end

  // Console sink: records each byte on the cycle it is popped.
  byte unsigned rx[$];
  always @(negedge clk) begin
    #1;
    if (tx_valid && tx_ready) rx.push_back(tx_data);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [31:0] a(input logic [7:0] off);
    return BASE + {24'h0, off};
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic bus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                     output logic [31:0] rdata, output int lat);
    mem_valid = 1'b1;
    mem_addr = addr;
    mem_wdata = data;
    mem_wstrb = strb;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_ready && lat < 50);
    check("bus_ack_seen", 64'(mem_ready), 64'd1);
    rdata = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, input string name);
    logic [31:0] d;
    int lat;
    bus(addr, data, strb, d, lat);
    check({name, "_lat"}, 64'(lat), 64'd1);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] d, input string name);
    int lat;
    bus(addr, 32'h0, 4'h0, d, lat);
    check({name, "_lat"}, 64'(lat), 64'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] d2;
    int rx_base;
    int n;

    resetn = 1'b0;
    mem_valid = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_wstrb = 4'h0;
    tx_ready = 1'b0;
    do_reset();

    check("rst_mem_ready", 64'(mem_ready), 64'd0);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_trap", 64'(trap), 64'd0);
    check("rst_exit_code", 64'(exit_code), 64'd0);
    check("rst_mem_rdata", 64'(mem_rdata), 64'd0);

    // Two console bytes with an always-ready sink.
    tx_ready = 1'b1;
    rx_base = rx.size();
    wr(a(OFF_CONSOLE), 32'h41, 4'h1, "con_41");
    wr(a(OFF_CONSOLE), 32'h42, 4'h1, "con_42");
    repeat (3) @(negedge clk);
    check("t1_rx_count", 64'(rx.size() - rx_base), 64'd2);
    check("t1_rx0", 64'(rx[rx_base]), 64'h41);
    check("t1_rx1", 64'(rx[rx_base + 1]), 64'h42);
    check("t1_empty", 64'(tx_valid), 64'd0);
    rd(a(OFF_CONSOLE), d, "t1_count_rd");
    check("t1_count", 64'(d), 64'd0);

    // Unselected window: never acked, no side effect.
    mem_valid = 1'b1;
    mem_addr = 32'h2000_0004;
    mem_wdata = 32'h1;
    mem_wstrb = 4'hF;
    repeat (5) begin
      @(negedge clk);
      check("unsel_no_ack", 64'(mem_ready), 64'd0);
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(negedge clk);
    check("unsel_no_exit", 64'(done), 64'd0);
    rd(a(8'h20), d, "unmapped_rd");
    check("unmapped_val", 64'(d), 64'd0);
    wr(a(OFF_CYCLE_LO), 32'hFFFF_FFFF, 4'hF, "ro_wr");

    // Fill with sink stalled, ninth write waits for a pop.
    do_reset();
    for (int i = 0; i < 8; i++) wr(a(OFF_CONSOLE), 32'(32'h10 + i), 4'h1, "fill");
    rd(a(OFF_STATUS), d, "t2_status_rd");
    check("t2_status_full", 64'(d), 64'h1);
    rd(a(OFF_CONSOLE), d, "t2_count_rd");
    check("t2_count_full", 64'(d), 64'd8);
    mem_valid = 1'b1;
    mem_addr = a(OFF_CONSOLE);
    mem_wdata = 32'h18;
    mem_wstrb = 4'h1;
    repeat (4) begin
      @(negedge clk);
      check("t2_stall_no_ack", 64'(mem_ready), 64'd0);
    end
    rx_base = rx.size();
    tx_ready = 1'b1;
    @(negedge clk);
    check("t2_ack_with_pop", 64'(mem_ready), 64'd1);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    repeat (12) @(negedge clk);
    check("t2_rx_count", 64'(rx.size() - rx_base), 64'd9);
    for (int i = 0; i < 9; i++) check("t2_rx_order", 64'(rx[rx_base + i]), 64'(8'h10 + i));

    // Exit with three bytes queued.
    do_reset();
    wr(a(OFF_CONSOLE), 32'h61, 4'h1, "q61");
    wr(a(OFF_CONSOLE), 32'h62, 4'h1, "q62");
    wr(a(OFF_CONSOLE), 32'h63, 4'h1, "q63");
    rx_base = rx.size();
    mem_valid = 1'b1;
    mem_addr = a(OFF_EXIT);
    mem_wdata = 32'h0;
    mem_wstrb = 4'hF;
    tx_ready = 1'b1;
    @(negedge clk);
    check("t3_exit_ack", 64'(mem_ready), 64'd1);
    check("t3_done_next", 64'(done), 64'd1);
    check("t3_trap_early", 64'(trap), 64'd0);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!trap && n < 20);
    check("t3_trap_delay", 64'(n), 64'd3);
    check("t3_exit_code", 64'(exit_code), 64'd0);
    check("t3_rx_count", 64'(rx.size() - rx_base), 64'd3);
    check("t3_rx0", 64'(rx[rx_base]), 64'h61);
    check("t3_rx2", 64'(rx[rx_base + 2]), 64'h63);
    wr(a(OFF_EXIT), 32'h55, 4'hF, "t3_late_exit");
    check("t3_exit_kept", 64'(exit_code), 64'd0);
    wr(a(OFF_CONSOLE), 32'h77, 4'h1, "t3_late_con");
    check("t3_no_push", 64'(tx_valid), 64'd0);
    rd(a(OFF_STATUS), d, "t3_status_rd");
    check("t3_status_done", 64'(d), 64'h4);
    rd(a(OFF_CYCLE_LO), d, "t3_lo_a");
    rd(a(OFF_CYCLE_LO), d2, "t3_lo_b");
    check("t3_cnt_frozen", 64'(d2), 64'(d));

    // Watchdog expiry with no exit write.
    do_reset();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 2000);
    check("t4_wd_cycles", 64'(n), 64'd1000);
    check("t4_wd_code", 64'(exit_code), 64'hDEAD_0001);
    @(negedge clk);
    check("t4_trap", 64'(trap), 64'd1);
    rd(a(OFF_CYCLE_LO), d, "t4_lo");
    check("t4_lo_frozen", 64'(d), 64'd1001);
    rd(a(OFF_CYCLE_HI), d, "t4_hi");
    check("t4_hi", 64'(d), 64'd0);

    // Counter carry across the 32-bit boundary.
    do_reset();
    preload_val = 64'h0000_0000_FFFF_FFFE;
    preload_seq++;
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    rd(a(OFF_CYCLE_LO), d, "t5_lo1");
    check("t5_lo1", 64'(d), 64'hFFFF_FFFE);
    rd(a(OFF_CYCLE_HI), d, "t5_hi1");
    check("t5_hi1", 64'(d), 64'd0);
    rd(a(OFF_CYCLE_LO), d, "t5_lo2");
    check("t5_lo2", 64'(d), 64'd2);
    rd(a(OFF_CYCLE_HI), d, "t5_hi2");
    check("t5_hi2", 64'(d), 64'd1);

    // Reset while in DRAIN with a full FIFO and a console write in flight.
    do_reset();
    for (int i = 0; i < 8; i++) wr(a(OFF_CONSOLE), 32'(32'hA0 + i), 4'h1, "t6_fill");
    wr(a(OFF_EXIT), 32'h7, 4'hF, "t6_exit");
    check("t6_drain", 64'(done), 64'd1);
    mem_valid = 1'b1;
    mem_addr = a(OFF_CONSOLE);
    mem_wdata = 32'h99;
    mem_wstrb = 4'h1;
    resetn = 1'b0;
    @(negedge clk);
    check("t6_no_ack", 64'(mem_ready), 64'd0);
    check("t6_done_clr", 64'(done), 64'd0);
    check("t6_trap_clr", 64'(trap), 64'd0);
    check("t6_fifo_empty", 64'(tx_valid), 64'd0);
    check("t6_exit_clr", 64'(exit_code), 64'd0);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    resetn = 1'b1;
    rd(a(OFF_STATUS), d, "t6_status_rd");
    check("t6_status_run", 64'(d), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
